alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 139 +++++++++++++
 tb/tb_alarm_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: rings on a rising alarm_flag, supports bounded snoozes,
// times out unanswered rings and drives a 1 Hz buzzer pattern.
module alarm_ctrl #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       alarm_flag,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer,
    output logic [1:0] snooze_cnt,
    output logic       missed
);

    localparam int unsigned MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned TW      = $clog2(MAX_SEC + 1);
    localparam int unsigned CW      = 2;

    localparam logic [TW-1:0] RING_LAST   = TW'(RING_SEC - 1);
    localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SEC - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic            flag_q;
    logic            armed;
    logic            trigger;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_d;
    logic [CW-1:0]   cnt_d;
    logic            buzzer_d;
    logic            missed_d;

    // armed suppresses the edge seen on the first clock after reset release
    assign trigger = alarm_flag & ~flag_q & armed;

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        cnt_d    = snooze_cnt;
        buzzer_d = buzzer;
        missed_d = 1'b0;
        case (state)
            IDLE: begin
                timer_d  = '0;
                cnt_d    = '0;
                buzzer_d = 1'b0;
                if (trigger) begin
                    state_d  = RING;
                    buzzer_d = 1'b1;
                end
            end
            RING: begin
                if (stop_btn) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    cnt_d    = '0;
                    buzzer_d = 1'b0;
                end else if (snooze_btn && (snooze_cnt < CNT_MAX)) begin
                    state_d  = SNOOZE;
                    timer_d  = '0;
                    cnt_d    = snooze_cnt + CW'(1);
                    buzzer_d = 1'b0;
                end else if (tick_1hz) begin
                    if (timer == RING_LAST) begin
                        state_d  = IDLE;
                        timer_d  = '0;
                        cnt_d    = '0;
                        buzzer_d = 1'b0;
                        missed_d = 1'b1;
                    end else begin
                        timer_d  = timer + TW'(1);
                        buzzer_d = ~buzzer;
                    end
                end
            end
            SNOOZE: begin
                buzzer_d = 1'b0;
                if (stop_btn) begin
                    state_d = IDLE;
                    timer_d = '0;
                    cnt_d   = '0;
                end else if (tick_1hz) begin
                    if (timer == SNOOZE_LAST) begin
                        state_d  = RING;
                        timer_d  = '0;
                        buzzer_d = 1'b1;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                cnt_d    = '0;
                buzzer_d = 1'b0;
            end
        endcase
    end

    // State, edge detector and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flag_q     <= 1'b0;
            armed      <= 1'b0;
            timer      <= '0;
            snooze_cnt <= '0;
            buzzer     <= 1'b0;
            missed     <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= state_d;
            flag_q     <= alarm_flag;
            armed      <= 1'b1;
            timer      <= timer_d;
            snooze_cnt <= cnt_d;
            buzzer     <= buzzer_d;
            missed     <= missed_d;
            ringing    <= (state_d == RING);
            snoozing   <= (state_d == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: seconds-level behavioural model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_alarm_ctrl;

    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SNOOZE = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       tick_1hz   = 1'b0;
    logic       alarm_flag = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn   = 1'b0;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;
    logic [1:0] snooze_cnt;
    logic       missed;

    alarm_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .alarm_flag(alarm_flag),
        .snooze_btn(snooze_btn),
        .stop_btn  (stop_btn),
        .ringing   (ringing),
        .snoozing  (snoozing),
        .buzzer    (buzzer),
        .snooze_cnt(snooze_cnt),
        .missed    (missed)
    );

    always #5 clk = ~clk;

    // Model: mode, seconds elapsed in the mode, snoozes used, edge memory
    typedef struct packed {
        int   mode;
        int   secs;
        int   snoozes;
        logic prev_flag;
        logic armed;
        logic missed;
    } model_t;

    model_t m;

    function automatic model_t m_reset();
        model_t r;
        r.mode = M_IDLE; r.secs = 0; r.snoozes = 0;
        r.prev_flag = 1'b0; r.armed = 1'b0; r.missed = 1'b0;
        return r;
    endfunction

    function automatic model_t to_idle(model_t s);
        model_t r = s;
        r.mode = M_IDLE; r.secs = 0; r.snoozes = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, logic f, logic t, logic sb, logic pb);
        model_t n = s;
        logic rise;
        rise = f && !s.prev_flag && s.armed;
        n.prev_flag = f;
        n.armed = 1'b1;
        n.missed = 1'b0;
        if (s.mode == M_IDLE) begin
            if (rise) begin n.mode = M_RING; n.secs = 0; end
        end else if (s.mode == M_RING) begin
            if (pb) n = to_idle(n);
            else if (sb && s.snoozes < MAX_SNOOZE) begin
                n.mode = M_SNOOZE; n.secs = 0; n.snoozes = s.snoozes + 1;
            end else if (t) begin
                n.secs = s.secs + 1;
                if (n.secs == RING_SEC) begin n = to_idle(n); n.missed = 1'b1; end
            end
        end else begin
            if (pb) n = to_idle(n);
            else if (t) begin
                n.secs = s.secs + 1;
                if (n.secs == SNOOZE_SEC) begin n.mode = M_RING; n.secs = 0; end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= model_step(m, alarm_flag, tick_1hz, snooze_btn, stop_btn);
    end

    int n_total = 0;
    int n_bad   = 0;
    int tcnt    = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Buzzer is on during even-numbered seconds of a ring
    task automatic check_model();
        check("model ringing",    int'(ringing),    int'(m.mode == M_RING));
        check("model snoozing",   int'(snoozing),   int'(m.mode == M_SNOOZE));
        check("model buzzer",     int'(buzzer),     int'(m.mode == M_RING && (m.secs % 2) == 0));
        check("model snooze_cnt", int'(snooze_cnt), m.snoozes);
        check("model missed",     int'(missed),     int'(m.missed));
    endtask

    function automatic bit tick_next();
        return tcnt == 9;
    endfunction

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge
    task automatic step(input logic f, input logic sb, input logic pb);
        alarm_flag = f;
        snooze_btn = sb;
        stop_btn   = pb;
        tick_1hz   = (tcnt == 9);
        tcnt       = (tcnt + 1) % 10;
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ring(output int ticks);
        int guard;
        ticks = 0;
        guard = 0;
        while (!ringing && guard < 60) begin
            if (tick_next()) ticks++;
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
    endtask

    int   buzz[$];
    int   nmiss;
    int   nrise;
    int   tk;
    int   k;
    int   n;
    logic prev_r;
    logic f_r;

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("reset ringing", int'(ringing), 0);
        check("reset buzzer", int'(buzzer), 0);
        check("reset snooze_cnt", int'(snooze_cnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // Unanswered ring: flag held 10 cycles, one ring, timeout after 4 ticks
        step(1'b1, 1'b0, 1'b0);
        check("A latency ringing", int'(ringing), 1);
        check("A entry buzzer", int'(buzzer), 1);
        nmiss = 0; nrise = 0; prev_r = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (ringing && tick_next()) buzz.push_back(int'(buzzer));
            step(i < 9, 1'b0, 1'b0);
            nmiss += int'(missed);
            if (ringing && !prev_r) nrise++;
            prev_r = ringing;
        end
        check("A buzz count", buzz.size(), 4);
        check("A buzz0", (buzz.size() > 0) ? buzz[0] : -1, 1);
        check("A buzz1", (buzz.size() > 1) ? buzz[1] : -1, 0);
        check("A buzz2", (buzz.size() > 2) ? buzz[2] : -1, 1);
        check("A buzz3", (buzz.size() > 3) ? buzz[3] : -1, 0);
        check("A missed pulses", nmiss, 1);
        check("A retrigger", nrise, 0);
        check("A idle ringing", int'(ringing), 0);

        // Snooze twice, third snooze ignored
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("B snoozing", int'(snoozing), 1);
        check("B cnt1", int'(snooze_cnt), 1);
        check("B buzzer off", int'(buzzer), 0);
        wait_ring(tk);
        check("B snooze ticks", tk, 3);
        check("B re-ring", int'(ringing), 1);
        step(1'b0, 1'b1, 1'b0);
        check("B cnt2", int'(snooze_cnt), 2);
        wait_ring(tk);
        check("B snooze ticks 2", tk, 3);
        step(1'b0, 1'b1, 1'b0);
        check("B sat ringing", int'(ringing), 1);
        check("B sat snoozing", int'(snoozing), 0);
        check("B sat cnt", int'(snooze_cnt), 2);
        step(1'b0, 1'b0, 1'b1);
        check("B stop ringing", int'(ringing), 0);
        check("B stop cnt", int'(snooze_cnt), 0);

        // Stop coincides with the timeout tick
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        wait_ring(tk);
        k = 0; n = 0;
        while (k < 3 && n < 60) begin
            if (tick_next()) k++;
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("C still ringing", int'(ringing), 1);
        while (!tick_next()) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("C ringing", int'(ringing), 0);
        check("C missed", int'(missed), 0);
        check("C cnt", int'(snooze_cnt), 0);
        step(1'b0, 1'b0, 1'b0);
        check("C missed later", int'(missed), 0);

        // Asynchronous reset mid-snooze with the flag held high across release
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("D snoozing", int'(snoozing), 1);
        step(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        alarm_flag = 1'b1;
        #1;
        check("D async snoozing", int'(snoozing), 0);
        check("D async cnt", int'(snooze_cnt), 0);
        check("D async ringing", int'(ringing), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        nrise = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            nrise += int'(ringing);
        end
        check("D no ring after release", nrise, 0);
        step(1'b0, 1'b0, 1'b0);

        // Flag re-rises during snooze: ignored, re-ring on schedule
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        tk = 0; n = 0;
        while (!ringing && n < 60) begin
            if (tick_next()) tk++;
            step(n == 2, 1'b0, 1'b0);
            n++;
        end
        check("E snooze ticks", tk, 3);
        check("E re-ring", int'(ringing), 1);
        check("E cnt", int'(snooze_cnt), 1);
        step(1'b0, 1'b0, 1'b1);

        // Randomized traffic against the model
        f_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(14) == 0) f_r = ~f_r;
            rst_n = ($urandom_range(699) != 0);
            step(f_r, $urandom_range(11) == 0, $urandom_range(44) == 0);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
